// File: rtl/sram_1rw_be.sv
// Single-port 1RW SRAM with req/ready handshake, byte enables, selectable
// read-during-write behaviour, optional output register and a post-reset clear sweep.
module sram_1rw_be #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int WRITE_MODE     = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NBYTES        = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  ready_o,
  input  logic                  we_i,
  input  logic [NBYTES-1:0]     be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data;

  assign accept  = req_i & ready_q & ~rst_i;
  assign ready_o = ready_q;

  always_comb begin
    old_word    = mem[addr_i];
    merged_word = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (be_i[b]) merged_word[8*b +: 8] = wdata_i[8*b +: 8];
    end
    resp_data  = (we_i && (WRITE_MODE == 0)) ? merged_word : old_word;
    resp_valid = accept & (~we_i | (WRITE_MODE != 2));
  end

  // ready only rises once the last word of the sweep has been written
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: ready_q <= 1'b1;
        default:  state_q <= ST_READY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && (state_q == ST_CLEAR)) begin
      mem[clr_cnt_q] <= '0;
    end else if (accept && we_i) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= resp_valid;
          if (resp_valid) s1_data_q <= resp_data;
        end
      end

      assign stage_valid = s1_valid_q;
      assign stage_data  = s1_data_q;
    end else begin : g_no_out_reg
      assign stage_valid = resp_valid;
      assign stage_data  = resp_data;
    end
  endgenerate

  // rdata only moves on a delivered response so consumers may sample it late
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= stage_valid;
      if (stage_valid) rdata_o <= stage_data;
    end
  end

endmodule

// File: tb/tb_sram_1rw_be.sv
// Drives four differently configured sram_1rw_be instances with shared stimulus and
// checks them against a word/byte-level memory model plus hand-computed values.
module tb_sram_1rw_be;

  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int NI    = 4;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [NB-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready  [NI];
  logic          rvalid [NI];
  logic [DW-1:0] rdata  [NI];

  int n_checks;
  int n_fails;

  // instance k configuration: write mode, output register, clear on reset
  function automatic int wm_of(input int k);
    if (k == 1) return 1;
    if (k == 2) return 2;
    return 0;
  endfunction

  function automatic bit or_of(input int k);
    return (k == 1) || (k == 3);
  endfunction

  function automatic bit cor_of(input int k);
    return k != 3;
  endfunction

  sram_1rw_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready[0]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));

  sram_1rw_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready[1]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

  sram_1rw_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready[2]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

  sram_1rw_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE(0), .OUT_REG(1), .CLEAR_ON_RESET(0)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready[3]), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid[3]), .rdata_o(rdata[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory contents with a per-bit known mask, and a list of
  // responses scheduled for the edge after which they must be visible.
  typedef struct {
    int            inst;
    int            due;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } resp_t;

  logic [DW-1:0] m_data [NI][DEPTH];
  logic [DW-1:0] m_mask [NI][DEPTH];
  resp_t         pend[$];
  bit            exp_ready  [NI];
  bit            exp_rvalid [NI];
  logic [DW-1:0] exp_rdata  [NI];
  logic [DW-1:0] exp_rmask  [NI];
  int            edge_no;
  int            since_rst;
  bit            model_live;

  task automatic model_access(input int k);
    logic [DW-1:0] old_d, old_m, new_d, new_m;
    resp_t r;
    old_d = m_data[k][addr];
    old_m = m_mask[k][addr];
    new_d = old_d;
    new_m = old_m;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        new_d[8*b +: 8] = wdata[8*b +: 8];
        new_m[8*b +: 8] = 8'hFF;
      end
    end
    if (we) begin
      m_data[k][addr] = new_d;
      m_mask[k][addr] = new_m;
    end
    r.inst = k;
    r.due  = edge_no + (or_of(k) ? 1 : 0);
    if (!we || wm_of(k) == 1) begin
      r.data = old_d;
      r.mask = old_m;
      pend.push_back(r);
    end else if (wm_of(k) == 0) begin
      r.data = new_d;
      r.mask = new_m;
      pend.push_back(r);
    end
  endtask

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      model_live = 1'b1;
      since_rst  = 0;
      pend.delete();
      for (int k = 0; k < NI; k++) begin
        exp_ready[k]  = 1'b0;
        exp_rvalid[k] = 1'b0;
        exp_rdata[k]  = '0;
        exp_rmask[k]  = '1;
        if (!cor_of(k)) begin
          for (int a = 0; a < DEPTH; a++) m_mask[k][a] = '0;
        end
      end
    end else if (model_live) begin
      for (int k = 0; k < NI; k++) begin
        if (req && exp_ready[k]) model_access(k);
        exp_rvalid[k] = 1'b0;
      end
      since_rst++;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == edge_no) begin
          exp_rvalid[pend[i].inst] = 1'b1;
          exp_rdata[pend[i].inst]  = pend[i].data;
          exp_rmask[pend[i].inst]  = pend[i].mask;
          pend.delete(i);
        end
      end
      for (int k = 0; k < NI; k++) begin
        if (!exp_ready[k] && since_rst >= (cor_of(k) ? DEPTH : 1)) begin
          exp_ready[k] = 1'b1;
          if (cor_of(k)) begin
            for (int a = 0; a < DEPTH; a++) begin
              m_data[k][a] = '0;
              m_mask[k][a] = '1;
            end
          end
        end
      end
    end
  end

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      n_checks += 3;
      if (ready[k] !== exp_ready[k]) begin
        n_fails++;
        $display("[TB] FAIL model_ready[%0d] t=%0t: actual %0b expected %0b", k, $time, ready[k], exp_ready[k]);
      end
      if (rvalid[k] !== exp_rvalid[k]) begin
        n_fails++;
        $display("[TB] FAIL model_rvalid[%0d] t=%0t: actual %0b expected %0b", k, $time, rvalid[k], exp_rvalid[k]);
      end
      if (((rdata[k] ^ exp_rdata[k]) & exp_rmask[k]) != '0) begin
        n_fails++;
        $display("[TB] FAIL model_rdata[%0d] t=%0t: actual %h expected %h (mask %h)", k, $time, rdata[k], exp_rdata[k], exp_rmask[k]);
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s t=%0t: actual %h expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [NB-1:0] b,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req   = r;
    we    = w;
    be    = b;
    addr  = a;
    wdata = d;
  endtask

  task automatic start_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    repeat (hold) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checkOutput("reset_ready", 64'(ready[k]), '0);
      checkOutput("reset_rvalid", 64'(rvalid[k]), '0);
      checkOutput("reset_rdata", rdata[k], '0);
    end
    rst = 1'b0;
  endtask

  // requests issued during the sweep must be ignored by the clearing instances
  task automatic wait_ready(input int stop_at);
    for (int i = 1; i <= stop_at; i++) begin
      @(negedge clk);
      checkOutput("sweep_ready", 64'(ready[0]), 64'(i == DEPTH));
      checkOutput("sweep_rvalid", 64'(rvalid[0]), '0);
      checkOutput("sweep_rdata", rdata[0], '0);
      checkOutput("nosweep_ready", 64'(ready[3]), 64'd1);
      if (i < DEPTH) begin
        req = 1'b1; we = 1'b1; be = '1; addr = AW'(i); wdata = '1;
      end else begin
        req = 1'b0; we = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    fork
      forever begin
        @(negedge clk);
        if (model_live) compare_all();
      end
    join_none

    start_reset(2);
    wait_ready(DEPTH);

    // every word reads back as zero after the sweep
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(a), '0);
      if (a > 0) begin
        checkOutput("zero_rvalid", 64'(rvalid[0]), 64'd1);
        checkOutput("zero_rdata", rdata[0], '0);
      end
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("zero_rdata_last", rdata[0], '0);

    // byte-merge and read-during-write behaviour across the write modes
    applyStimulus(1'b1, 1'b1, 8'hFF, 4'd5, 64'h1122334455667788);
    applyStimulus(1'b1, 1'b1, 8'h0F, 4'd5, 64'hAAAAAAAAAAAAAAAA);
    applyStimulus(1'b1, 1'b0, 8'h00, 4'd5, '0);
    applyStimulus(1'b1, 1'b1, 8'hFF, 4'd3, 64'h5);
    checkOutput("merge_rvalid", 64'(rvalid[0]), 64'd1);
    checkOutput("merge_rdata", rdata[0], 64'h11223344AAAAAAAA);
    checkOutput("merge_rdata_wm2", rdata[2], 64'h11223344AAAAAAAA);
    applyStimulus(1'b1, 1'b1, 8'hFF, 4'd3, 64'h9);
    checkOutput("wfirst_rdata_5", rdata[0], 64'h5);
    checkOutput("oreg_read_rdata", rdata[1], 64'h11223344AAAAAAAA);
    checkOutput("nochange_rvalid", 64'(rvalid[2]), '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("wfirst_rdata_9", rdata[0], 64'h9);
    checkOutput("wfirst_rvalid", 64'(rvalid[0]), 64'd1);
    checkOutput("rfirst_old0", rdata[1], '0);
    checkOutput("rfirst_rvalid0", 64'(rvalid[1]), 64'd1);
    checkOutput("nochange_rvalid2", 64'(rvalid[2]), '0);
    checkOutput("nochange_rdata", rdata[2], 64'h11223344AAAAAAAA);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("rfirst_old5", rdata[1], 64'h5);
    checkOutput("rfirst_rvalid5", 64'(rvalid[1]), 64'd1);
    checkOutput("wfirst_idle_rvalid", 64'(rvalid[0]), '0);
    checkOutput("wfirst_hold", rdata[0], 64'h9);

    // back-to-back reads through the output register arrive two cycles later in order
    applyStimulus(1'b1, 1'b0, '0, 4'd5, '0);
    applyStimulus(1'b1, 1'b0, '0, 4'd3, '0);
    checkOutput("b2b_gap_rvalid", 64'(rvalid[1]), '0);
    applyStimulus(1'b1, 1'b0, '0, 4'd5, '0);
    checkOutput("b2b_rvalid0", 64'(rvalid[1]), 64'd1);
    checkOutput("b2b_rdata0", rdata[1], 64'h11223344AAAAAAAA);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("b2b_rvalid1", 64'(rvalid[1]), 64'd1);
    checkOutput("b2b_rdata1", rdata[1], 64'h9);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("b2b_rvalid2", 64'(rvalid[1]), 64'd1);
    checkOutput("b2b_rdata2", rdata[1], 64'h11223344AAAAAAAA);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("b2b_done", 64'(rvalid[1]), '0);

    // reset with reads in flight, then reset again part-way through the sweep
    applyStimulus(1'b1, 1'b0, '0, 4'd1, '0);
    applyStimulus(1'b1, 1'b0, '0, 4'd2, '0);
    start_reset(1);
    wait_ready(7);
    start_reset(3);
    wait_ready(DEPTH);

    for (int round = 0; round < 3; round++) begin
      for (int n = 0; n < 300; n++) begin
        applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom),
                      AW'($urandom), {$urandom, $urandom});
      end
      start_reset(1 + int'($urandom_range(0, 3)));
      wait_ready(DEPTH);
    end

    repeat (4) applyStimulus(1'b0, 1'b0, '0, '0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
